// File: rtl/nn_layer_in_collect.sv
// Serial-to-parallel input collector for a 6-input neuron layer: gathers N_IN beats
// plus a feedback operand and presents them under valid/ready. Optional macro: NN_COLLECT_DBUF_EN.
module nn_layer_in_collect #(
  parameter int N_IN = 6,
  parameter int DW   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  input  logic               s_last,
  input  logic [DW-1:0]      fb_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [N_IN*DW-1:0] m_vec,
  output logic [DW-1:0]      m_fb,
  output logic               err_frame
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_IN - 1);

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    RESYNC
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_nextIdx;
  logic [DW-1:0]      r_slot [N_IN];
  logic [N_IN*DW-1:0] r_mVec;
  logic [DW-1:0]      r_mFb;
  logic               r_mValid;
  logic               r_errFrame;
  logic               w_rdy;
  logic               w_complete;
  logic               w_err;
  logic               w_atLast;
  logic               w_handoff;
  logic [N_IN*DW-1:0] w_frameVec;
`ifdef NN_COLLECT_DBUF_EN
  logic [DW-1:0]      r_shadowFb;
  logic [N_IN*DW-1:0] w_shadowVec;
`endif

  assign w_atLast  = (r_idx == LAST_IDX);
  assign w_handoff = r_mValid & m_ready;
  assign s_ready   = w_rdy & ~rst;
  assign m_valid   = r_mValid;
  assign m_vec     = r_mVec;
  assign m_fb      = r_mFb;
  assign err_frame = r_errFrame;

  always_comb begin
    w_nextState = r_state;
    w_nextIdx   = r_idx;
    w_complete  = 1'b0;
    w_err       = 1'b0;
    w_rdy       = 1'b0;
    case (r_state)
      COLLECT: begin
        w_rdy = 1'b1;
        if (s_valid) begin
          if (w_atLast) begin
            w_nextIdx = '0;
            if (s_last) begin
              w_complete = 1'b1;
`ifdef NN_COLLECT_DBUF_EN
              // A finished frame parks in the slots only if the output bank is still occupied
              if (r_mValid && !m_ready) begin
                w_nextState = HOLD;
              end
`else
              w_nextState = HOLD;
`endif
            end else begin
              w_err       = 1'b1;
              w_nextState = RESYNC;
            end
          end else if (s_last) begin
            w_err     = 1'b1;
            w_nextIdx = '0;
          end else begin
            w_nextIdx = r_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_handoff) begin
          w_nextState = COLLECT;
        end
      end
      RESYNC: begin
        w_rdy = 1'b1;
        if (s_valid && s_last) begin
          w_nextIdx   = '0;
          w_nextState = COLLECT;
        end
      end
      default: begin
        w_nextState = COLLECT;
        w_nextIdx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_idx      <= '0;
      r_errFrame <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_idx      <= w_nextIdx;
      r_errFrame <= w_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) begin
        r_slot[k] <= '0;
      end
    end else if (r_state == COLLECT && s_valid) begin
      r_slot[r_idx] <= s_data;
    end
  end

  // The completing beat bypasses its slot so the vector is ready one cycle after the handshake
  always_comb begin
    w_frameVec = '0;
    for (int k = 0; k < N_IN - 1; k++) begin
      w_frameVec[k*DW +: DW] = r_slot[k];
    end
    w_frameVec[(N_IN-1)*DW +: DW] = s_data;
  end

`ifdef NN_COLLECT_DBUF_EN
  always_comb begin
    w_shadowVec = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_shadowVec[k*DW +: DW] = r_slot[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mValid   <= 1'b0;
      r_mVec     <= '0;
      r_mFb      <= '0;
      r_shadowFb <= '0;
    end else if (w_complete && (!r_mValid || m_ready)) begin
      r_mValid <= 1'b1;
      r_mVec   <= w_frameVec;
      r_mFb    <= fb_in;
    end else if (w_complete) begin
      r_shadowFb <= fb_in;
    end else if (r_state == HOLD && w_handoff) begin
      r_mValid <= 1'b1;
      r_mVec   <= w_shadowVec;
      r_mFb    <= r_shadowFb;
    end else if (w_handoff) begin
      r_mValid <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mValid <= 1'b0;
      r_mVec   <= '0;
      r_mFb    <= '0;
    end else if (w_complete) begin
      r_mValid <= 1'b1;
      r_mVec   <= w_frameVec;
      r_mFb    <= fb_in;
    end else if (w_handoff) begin
      r_mValid <= 1'b0;
    end
  end
`endif

endmodule
